// File: rtl/umi_write_arbiter_pkg.sv
// Shared types and helpers for the UMI write arbiter: FSM encoding, default packet width,
// and the index-width helper used for grant_id and the round-robin pointer.
package umi_write_arbiter_pkg;

  localparam int UMI_PW = 256;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Index width; a single requester still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/umi_write_arbiter_if.sv
// Requester-side and bridge-side signals of the UMI write arbiter.
// The arbiter uses the slave modport; requesters plus bridge use master.
interface umi_write_arbiter_if
  import umi_write_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = UMI_PW
);
  localparam int IW = idx_w(N);

  logic [N*PW-1:0] in_packet;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [PW-1:0]   out_packet;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   grant_id;
  logic            busy;
  logic            err_timeout;
  logic            err_clr;

  modport master (
    output in_packet, in_valid, out_ready, err_clr,
    input  in_ready, out_packet, out_valid, grant_id, busy, err_timeout
  );

  modport slave (
    input  in_packet, in_valid, out_ready, err_clr,
    output in_ready, out_packet, out_valid, grant_id, busy, err_timeout
  );

endinterface

// File: rtl/umi_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping modulo N.
// Doubling the request vector turns the wrap into a single lowest-set-bit search.
module umi_write_arbiter_rr_pick
  import umi_write_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [2*N-1:0] masked;

  // Lower copy only keeps requesters at or above ptr; upper copy holds the wrapped ones.
  generate
    for (genvar gi = 0; gi < 2*N; gi++) begin : g_mask
      if (gi < N) begin : g_lo
        assign masked[gi] = req[gi] & (IW'(gi) >= ptr);
      end else begin : g_hi
        assign masked[gi] = req[gi-N];
      end
    end
  endgenerate

  always_comb begin
    gnt_idx = '0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (masked[j]) begin
        gnt_idx = IW'(j % N);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/umi_write_arbiter.sv
// Round-robin arbiter sharing one UMI write bridge between N requesters: one whole
// transaction per grant, packet held until the bridge acks, then one forced valid-low cycle.
module umi_write_arbiter
  import umi_write_arbiter_pkg::*;
#(
  parameter int N       = 4,
  parameter int PW      = UMI_PW,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  umi_write_arbiter_if.slave  bus
);

  localparam int IW = idx_w(N);
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit              WDOG_EN  = (TIMEOUT > 0);
  localparam logic [WW-1:0]   WDOG_MAX = WDOG_EN ? WW'(TIMEOUT) : '0;
  localparam logic [WW-1:0]   WDOG_PRE = WDOG_EN ? WW'(TIMEOUT - 1) : '0;

  arb_state_t    state_reg;
  logic [IW-1:0] rr_ptr_reg;
  logic [WW-1:0] wdog_reg;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [IW-1:0] ptr_next;
  logic          wdog_set;
  logic [PW-1:0] pkt_arr [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_req
      assign pkt_arr[gi] = bus.in_packet[gi*PW +: PW];
      // Ack is passed straight through to the grantee in the same cycle.
      assign bus.in_ready[gi] = (state_reg == ARB_BUSY) && bus.out_ready &&
                                (bus.grant_id == IW'(gi));
    end
  endgenerate

  umi_write_arbiter_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req     (bus.in_valid),
    .ptr     (rr_ptr_reg),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign ptr_next = (int'(bus.grant_id) == N - 1) ? '0 : bus.grant_id + 1'b1;

  // Flag while saturated too, so a clear during a still-stuck transaction re-arms next cycle.
  assign wdog_set = WDOG_EN && (state_reg == ARB_BUSY) && !bus.out_ready &&
                    ((wdog_reg == WDOG_PRE) || (wdog_reg == WDOG_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ARB_IDLE;
      bus.out_valid   <= 1'b0;
      bus.out_packet  <= '0;
      bus.grant_id    <= '0;
      bus.busy        <= 1'b0;
      bus.err_timeout <= 1'b0;
      rr_ptr_reg      <= '0;
      wdog_reg        <= '0;
    end else begin
      if (bus.err_clr) begin
        bus.err_timeout <= 1'b0;
      end else if (wdog_set) begin
        bus.err_timeout <= 1'b1;
      end

      case (state_reg)
        ARB_IDLE: begin
          if (pick_any) begin
            bus.out_packet <= pkt_arr[pick_idx];
            bus.grant_id   <= pick_idx;
            bus.out_valid  <= 1'b1;
            bus.busy       <= 1'b1;
            wdog_reg       <= '0;
            state_reg      <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // The write cannot be withdrawn, so the watchdog only reports and never aborts.
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            rr_ptr_reg    <= ptr_next;
            wdog_reg      <= '0;
            state_reg     <= ARB_IDLE;
          end else if (wdog_reg != WDOG_MAX) begin
            wdog_reg <= wdog_reg + 1'b1;
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_umi_write_arbiter.sv
// Self-checking bench for umi_write_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level round-robin model.
module tb_umi_write_arbiter;

  localparam int N  = 4;
  localparam int PW = 64;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  umi_write_arbiter_if #(.N(N), .PW(PW)) bus ();

  umi_write_arbiter #(.N(N), .PW(PW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] iv, input logic ordy, input logic clr);
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.err_clr   = clr;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant_id", bus.grant_id, 0);
    chk("rst_err", bus.err_timeout, 0);
    chk("rst_out_packet", bus.out_packet, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] iv;
    logic         ordy;
    logic [N-1:0] exp_rdy;
    logic         exp_ov;
    logic [1:0]   exp_gid;
  } vec_t;

  vec_t         tbl [16];
  logic [63:0]  pk [N];

  // Randomized-phase state: per-requester packet lists and the reference model.
  logic [63:0]  plist [N][100];
  int           head [N];
  int           cnt [N];
  bit           m_busy;
  int           m_gid, m_ptr, ack_dly, ack_wait, landed;

  initial begin
    rst_n = 1'b0;
    bus.in_packet = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    bus.err_clr   = 1'b0;
    for (int i = 0; i < N; i++) begin
      pk[i] = 64'h0000_1000_CAFE_0000 | 64'(i);
      bus.in_packet[i*PW +: PW] = pk[i];
    end

    // Fairness with 0101 (expect 0,2,0,2) then all four with fast acks (rotating).
    tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[1]  = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[2]  = '{4'b0101, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[3]  = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[4]  = '{4'b0101, 1'b1, 4'b0100, 1'b0, 2'd2};
    tbl[5]  = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[6]  = '{4'b0101, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[7]  = '{4'b0101, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0100, 1'b0, 2'd2};
    tbl[9]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3};
    tbl[10] = '{4'b1111, 1'b1, 4'b1000, 1'b0, 2'd3};
    tbl[11] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[12] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[13] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[14] = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd1};
    tbl[15] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};

    do_reset();
    for (int r = 0; r < 16; r++) begin
      drive(tbl[r].iv, tbl[r].ordy, 1'b0);
      chk("tbl_in_ready", bus.in_ready, tbl[r].exp_rdy);
      tick();
      chk("tbl_out_valid", bus.out_valid, tbl[r].exp_ov);
      chk("tbl_busy", bus.busy, tbl[r].exp_ov);
      chk("tbl_grant_id", bus.grant_id, tbl[r].exp_gid);
      if (tbl[r].exp_ov) chk("tbl_out_packet", bus.out_packet, pk[tbl[r].exp_gid]);
      $display("vec %0d iv=%b ordy=%b in_ready=%b out_valid=%b grant_id=%0d",
               r, tbl[r].iv, tbl[r].ordy, bus.in_ready, bus.out_valid, bus.grant_id);
    end

    // Single request from port 1, ack on the third BUSY cycle.
    do_reset();
    drive(4'b0010, 1'b0, 1'b0);
    chk("single_rdy_idle", bus.in_ready, 0);
    tick();
    chk("single_latency", bus.out_valid, 1);
    chk("single_gid", bus.grant_id, 1);
    chk("single_pkt", bus.out_packet, pk[1]);
    drive(4'b0010, 1'b0, 1'b0); chk("single_hold_rdy", bus.in_ready, 0); tick();
    drive(4'b0010, 1'b0, 1'b0); tick();
    chk("single_hold_ov", bus.out_valid, 1);
    drive(4'b0010, 1'b1, 1'b0);
    chk("single_ack_rdy", bus.in_ready, 4'b0010);
    tick();
    chk("single_gap_ov", bus.out_valid, 0);
    chk("single_gap_busy", bus.busy, 0);
    chk("single_gap_gid", bus.grant_id, 1);
    // rr_ptr must now be 2: with 0111 pending the winner is 2, not 0 or 1.
    drive(4'b0111, 1'b0, 1'b0);
    chk("gap_rdy", bus.in_ready, 0);
    tick();
    chk("ptr2_ov", bus.out_valid, 1);
    chk("ptr2_gid", bus.grant_id, 2);
    $display("single: port 1 acked, next grant %0d after one idle cycle", bus.grant_id);

    // Grantee withdraws mid-BUSY; latched packet still completes.
    drive(4'b0000, 1'b0, 1'b0); tick();
    chk("drop_pkt", bus.out_packet, pk[2]);
    chk("drop_ov", bus.out_valid, 1);
    drive(4'b0000, 1'b1, 1'b0);
    chk("drop_ack_rdy", bus.in_ready, 4'b0100);
    tick();
    chk("drop_done_ov", bus.out_valid, 0);

    // Watchdog: ptr=3, port 0 wins and is never acked.
    drive(4'b0001, 1'b0, 1'b0); tick();
    chk("wd_gid", bus.grant_id, 0);
    for (int k = 1; k <= TO; k++) begin
      drive(4'b0001, 1'b0, 1'b0); tick();
      chk("wd_err_count", bus.err_timeout, (k >= TO) ? 1 : 0);
    end
    drive(4'b0001, 1'b0, 1'b1); tick();
    chk("wd_clr_wins", bus.err_timeout, 0);
    drive(4'b0001, 1'b0, 1'b0); tick();
    chk("wd_resets", bus.err_timeout, 1);
    chk("wd_no_abort", bus.out_valid, 1);
    drive(4'b0000, 1'b1, 1'b1);
    chk("wd_ack_rdy", bus.in_ready, 4'b0001);
    tick();
    chk("wd_clr_ack", bus.err_timeout, 0);
    drive(4'b0000, 1'b0, 1'b0); tick();
    chk("wd_stay_clr", bus.err_timeout, 0);
    $display("watchdog: timeout raised, cleared, transaction acked");

    // Async reset mid-BUSY: ptr=1, port 3 wins.
    drive(4'b1000, 1'b0, 1'b0); tick();
    chk("ar_gid3", bus.grant_id, 3);
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("ar_ov", bus.out_valid, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_rdy", bus.in_ready, 0);
    chk("ar_gid", bus.grant_id, 0);
    drive(4'b0000, 1'b0, 1'b0); tick();
    rst_n = 1'b1;
    drive(4'b1111, 1'b0, 1'b0); tick();
    chk("ar_ptr0", bus.grant_id, 0);
    drive(4'b0000, 1'b1, 1'b0); tick();

    // Randomized traffic: 100 writes spread over the four ports.
    do_reset();
    for (int i = 0; i < N; i++) begin head[i] = 0; cnt[i] = 0; end
    for (int k = 0; k < 100; k++) begin
      int p;
      p = int'($urandom_range(0, N-1));
      plist[p][cnt[p]] = {$urandom, $urandom};
      cnt[p]++;
    end
    m_busy = 0; m_gid = 0; m_ptr = 0; ack_dly = 0; ack_wait = 0; landed = 0;
    for (int cyc = 0; cyc < 4000 && landed < 100; cyc++) begin
      logic [N-1:0] iv;
      logic [N-1:0] exp_rdy;
      logic         ordy;
      iv = '0;
      for (int i = 0; i < N; i++) begin
        if (head[i] < cnt[i]) begin
          bus.in_packet[i*PW +: PW] = plist[i][head[i]];
          if ($urandom_range(0, 3) != 0) iv[i] = 1'b1;
        end else begin
          bus.in_packet[i*PW +: PW] = {$urandom, $urandom};
        end
      end
      ordy = m_busy ? (ack_wait == ack_dly) : ($urandom_range(0, 3) == 0);
      drive(iv, ordy, 1'b0);
      exp_rdy = (m_busy && ordy) ? N'(1 << m_gid) : '0;
      chk("rnd_in_ready", bus.in_ready, exp_rdy);
      if (m_busy && ordy) begin
        chk("rnd_landed_pkt", bus.out_packet, plist[m_gid][head[m_gid]]);
        $display("ack port=%0d pkt=%h n=%0d", m_gid, bus.out_packet, landed);
        head[m_gid]++;
        landed++;
      end
      tick();
      if (m_busy) begin
        if (ordy) begin
          m_busy = 0;
          m_ptr  = (m_gid + 1) % N;
        end else begin
          ack_wait++;
        end
      end else if (iv != 0) begin
        bit found;
        found = 0;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (!found && iv[j]) begin
            m_gid = j;
            found = 1;
          end
        end
        m_busy   = 1;
        ack_wait = 0;
        ack_dly  = int'($urandom_range(0, 4));
      end
      chk("rnd_out_valid", bus.out_valid, m_busy);
      chk("rnd_busy", bus.busy, m_busy);
      chk("rnd_grant_id", bus.grant_id, m_gid);
      chk("rnd_err", bus.err_timeout, 0);
      if (m_busy) chk("rnd_out_packet", bus.out_packet, plist[m_gid][head[m_gid]]);
    end
    chk("rnd_all_landed", landed, 100);
    for (int i = 0; i < N; i++) chk("rnd_queue_drained", head[i], cnt[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
